// File: rtl/if_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decode handoff and redirect inputs.
// master = fetch unit, slave = memory/decode environment.
interface if_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [2:0]  npc_op;
    logic [31:0] br_pc;
    logic [31:0] br_imm;
    logic [31:0] jalr_base;

    modport master (
        output imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
               npc_op, br_pc, br_imm, jalr_base
    );

    modport slave (
        input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
               npc_op, br_pc, br_imm, jalr_base
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: PC sequencing, in-order imem requests, redirect flush/drop and a small instruction FIFO.
// Optional macro FETCH_ALIGN_CHK_EN: misaligned redirect targets set fetch_err and halt fetching.
module if_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rstn,
`ifdef FETCH_ALIGN_CHK_EN
    output logic       fetch_err,
`endif
    if_fetch_if.master fif
);
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    localparam logic [2:0] OP_BR   = 3'b001;
    localparam logic [2:0] OP_JAL  = 3'b010;
    localparam logic [2:0] OP_JALR = 3'b100;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]      buf_inst_q [BUF_DEPTH];
    logic [31:0]      buf_pc_q   [BUF_DEPTH];
`ifdef FETCH_ALIGN_CHK_EN
    logic             err_q, err_d;
    logic             misalign_c;
`endif

    logic             redirect_c;
    logic [31:0]      target_raw_c;
    logic [31:0]      target_c;
    logic             req_valid_c;
    logic             req_fire_c;
    logic             rsp_c;
    logic             push_c;
    logic             pop_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Redirect decode and target generation; unknown npc_op codes behave as sequential fetch.
    always_comb begin
        redirect_c = (state_q != ST_HALT) &&
                     ((fif.npc_op == OP_BR) || (fif.npc_op == OP_JAL) || (fif.npc_op == OP_JALR));
        if (fif.npc_op == OP_JALR) begin
            target_raw_c = (fif.jalr_base + fif.br_imm) & ~32'h1;
        end else begin
            target_raw_c = fif.br_pc + fif.br_imm;
        end
`ifdef FETCH_ALIGN_CHK_EN
        target_c   = target_raw_c;
        misalign_c = (target_raw_c[1:0] != 2'b00);
`else
        target_c   = target_raw_c & ~32'h3;
`endif
    end

    // Request throttle counts both in-flight and buffered words so the FIFO can never overflow.
    always_comb begin
        req_valid_c = (state_q == ST_RUN) && !redirect_c &&
                      ((SUM_W'(out_q) + SUM_W'(cnt_q)) < SUM_W'(BUF_DEPTH));
        req_fire_c  = req_valid_c && fif.imem_req_ready;
        rsp_c       = fif.imem_rsp_valid;
        pop_c       = (cnt_q != '0) && fif.inst_ready && !redirect_c;
        push_c      = rsp_c && !redirect_c && (drop_q == '0) && (state_q != ST_HALT);
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        drop_d   = drop_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        out_d    = out_q + CNT_W'(req_fire_c) - CNT_W'(rsp_c);
`ifdef FETCH_ALIGN_CHK_EN
        err_d    = err_q;
`endif
        if (state_q == ST_BOOT) begin
            state_d = ST_RUN;
        end

        if (redirect_c) begin
            // Everything still in flight belongs to the old path; a response arriving now is discarded.
            drop_d   = out_q - CNT_W'(rsp_c);
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
`ifdef FETCH_ALIGN_CHK_EN
            if (misalign_c) begin
                state_d = ST_HALT;
                err_d   = 1'b1;
            end else begin
                pc_d     = target_c;
                rsp_pc_d = target_c;
            end
`else
            pc_d     = target_c;
            rsp_pc_d = target_c;
`endif
        end else begin
            if (req_fire_c) begin
                pc_d = pc_q + 32'd4;
            end
            if (rsp_c && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
            if (push_c) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (pop_c) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            buf_inst_q <= '{default: '0};
            buf_pc_q   <= '{default: '0};
`ifdef FETCH_ALIGN_CHK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
`ifdef FETCH_ALIGN_CHK_EN
            err_q    <= err_d;
`endif
            if (push_c) begin
                buf_inst_q[wr_ptr_q] <= fif.imem_rsp_data;
                buf_pc_q[wr_ptr_q]   <= rsp_pc_q;
            end
        end
    end

    assign fif.imem_req_valid = req_valid_c;
    assign fif.imem_addr      = pc_q;
    assign fif.inst_valid     = (cnt_q != '0);
    assign fif.inst           = buf_inst_q[rd_ptr_q];
    assign fif.inst_pc        = buf_pc_q[rd_ptr_q];
`ifdef FETCH_ALIGN_CHK_EN
    assign fetch_err          = err_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: queue-based reference of in-flight words and the decode FIFO,
// plus directed scenarios for sequential fetch, stall, redirects, wrap, alignment and reset.
module tb_if_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    if_fetch_if fif ();
`ifdef FETCH_ALIGN_CHK_EN
    logic fetch_err;
`endif

    if_fetch #(.RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
`ifdef FETCH_ALIGN_CHK_EN
        .fetch_err (fetch_err),
`endif
        .fif       (fif)
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        bit          stale;
    } flight_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    flight_t     fl_q[$];
    entry_t      fifo_q[$];
    logic [31:0] cons_q[$];
    logic [31:0] m_pc;
    bit          m_booted, m_halted, m_err;
    int unsigned cyc, n_tests, n_fail;
    int unsigned lat_min, lat_max;

    logic [2:0]  s_op;
    logic [31:0] s_br_pc, s_imm, s_jb;
    logic        s_inst_ready, s_req_ready;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive inputs, compare against the reference, advance the reference, cross the edge.
    task automatic step();
        logic        redir, fire, mis;
        logic [31:0] tgt;
        bit          exp_rv;
        flight_t     f;
        fif.npc_op         = s_op;
        fif.br_pc          = s_br_pc;
        fif.br_imm         = s_imm;
        fif.jalr_base      = s_jb;
        fif.inst_ready     = s_inst_ready;
        fif.imem_req_ready = s_req_ready;
        if (fl_q.size() != 0 && fl_q[0].due <= cyc) begin
            fif.imem_rsp_valid = 1'b1;
            fif.imem_rsp_data  = mem_word(fl_q[0].addr);
        end else begin
            fif.imem_rsp_valid = 1'b0;
            fif.imem_rsp_data  = $urandom;
        end
        #2;
        redir  = !m_halted && (s_op == 3'b001 || s_op == 3'b010 || s_op == 3'b100);
        exp_rv = m_booted && !m_halted && !redir && ((fl_q.size() + fifo_q.size()) < DEPTH);
        chk("req_valid", 32'(fif.imem_req_valid), 32'(exp_rv));
        if (!m_halted) chk("imem_addr", fif.imem_addr, m_pc);
        chk("inst_valid", 32'(fif.inst_valid), 32'(fifo_q.size() != 0));
        if (fifo_q.size() != 0) begin
            chk("inst_pc", fif.inst_pc, fifo_q[0].pc);
            chk("inst", fif.inst, fifo_q[0].word);
        end
`ifdef FETCH_ALIGN_CHK_EN
        chk("fetch_err", 32'(fetch_err), 32'(m_err));
`endif
        if (fif.inst_valid && s_inst_ready && !redir) cons_q.push_back(fif.inst_pc);

        fire = exp_rv && s_req_ready;
        if (fifo_q.size() != 0 && s_inst_ready && !redir) void'(fifo_q.pop_front());
        if (fif.imem_rsp_valid) begin
            f = fl_q.pop_front();
            if (!redir && !f.stale && !m_halted) fifo_q.push_back('{f.addr, mem_word(f.addr)});
        end
        if (redir) begin
            tgt = (s_op == 3'b100) ? ((s_jb + s_imm) & ~32'h1) : (s_br_pc + s_imm);
            fifo_q.delete();
            foreach (fl_q[i]) fl_q[i].stale = 1'b1;
`ifdef FETCH_ALIGN_CHK_EN
            mis = (tgt[1:0] != 2'b00);
`else
            mis = 1'b0;
            tgt = tgt & ~32'h3;
`endif
            if (mis) begin
                m_halted = 1'b1;
                m_err    = 1'b1;
            end else begin
                m_pc = tgt;
            end
        end
        if (fire) begin
            fl_q.push_back('{m_pc, cyc + $urandom_range(lat_max, lat_min), 1'b0});
            m_pc = m_pc + 32'd4;
        end
        m_booted = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Asynchronous reset assertion mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        rstn               = 1'b0;
        s_op               = 3'b000;
        fif.npc_op         = 3'b000;
        fif.imem_rsp_valid = 1'b0;
        #1;
        chk("rst req_valid", 32'(fif.imem_req_valid), 32'd0);
        chk("rst inst_valid", 32'(fif.inst_valid), 32'd0);
        chk("rst inst", fif.inst, 32'd0);
        chk("rst inst_pc", fif.inst_pc, 32'd0);
        chk("rst imem_addr", fif.imem_addr, RESET_PC);
`ifdef FETCH_ALIGN_CHK_EN
        chk("rst fetch_err", 32'(fetch_err), 32'd0);
`endif
        fl_q.delete();
        fifo_q.delete();
        cons_q.delete();
        m_pc     = RESET_PC;
        m_booted = 1'b0;
        m_halted = 1'b0;
        m_err    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic run_until(input int unsigned n, input int unsigned budget);
        int unsigned k;
        k = 0;
        while (cons_q.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("progress", 32'(cons_q.size() >= n), 32'd1);
    endtask

    task automatic set_redirect(input logic [2:0] op, input logic [31:0] bpc,
                                input logic [31:0] imm, input logic [31:0] jb);
        s_op    = op;
        s_br_pc = bpc;
        s_imm   = imm;
        s_jb    = jb;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        lat_min = 1; lat_max = 1;
        s_op = 3'b000; s_br_pc = '0; s_imm = '0; s_jb = '0;
        s_inst_ready = 1'b1; s_req_ready = 1'b1;
        fif.npc_op = 3'b000; fif.br_pc = '0; fif.br_imm = '0; fif.jalr_base = '0;
        fif.inst_ready = 1'b1; fif.imem_req_ready = 1'b1;
        fif.imem_rsp_valid = 1'b0; fif.imem_rsp_data = '0;
        #1;

        // Sequential fetch after reset.
        do_reset();
        run_until(4, 40);
        for (int i = 0; i < 4; i++) chk("seq pc", cons_q[i], 32'(4 * i));

        // Decode stall: buffer fills, requests stop, nothing lost.
        s_inst_ready = 1'b0;
        repeat (10) step();
        chk("stall inst_valid", 32'(fif.inst_valid), 32'd1);
        chk("stall req_valid", 32'(fif.imem_req_valid), 32'd0);
        s_inst_ready = 1'b1;
        cons_q.delete();
        run_until(4, 40);
        chk("stall resume pc", cons_q[0], 32'h10);
        for (int i = 0; i < 3; i++) chk("stall consecutive", cons_q[i + 1], cons_q[i] + 32'd4);

        // Branch with two stale words in flight.
        lat_min = 3; lat_max = 3;
        do_reset();
        for (int k = 0; k < 10 && fl_q.size() < 2; k++) step();
        chk("two in flight", 32'(fl_q.size()), 32'd2);
        set_redirect(3'b001, 32'h10, 32'h20, 32'h0);
        cons_q.delete();
        step();
        s_op = 3'b000;
        run_until(2, 40);
        chk("branch pc0", cons_q[0], 32'h30);
        chk("branch pc1", cons_q[1], 32'h34);

        // jalr clears bit 0; a second redirect one cycle later wins.
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (3) step();
        set_redirect(3'b100, 32'h0, 32'h0, 32'h101);
        cons_q.delete();
        step();
        s_op = 3'b000;
        run_until(1, 20);
        chk("jalr pc", cons_q[0], 32'h100);
        set_redirect(3'b100, 32'h0, 32'h0, 32'h101);
        step();
        set_redirect(3'b010, 32'h200, 32'h40, 32'h0);
        cons_q.delete();
        step();
        s_op = 3'b000;
        run_until(2, 20);
        chk("second redirect pc0", cons_q[0], 32'h240);
        chk("second redirect pc1", cons_q[1], 32'h244);

        // PC wrap-around at the top of the address space.
        set_redirect(3'b010, 32'hFFFF_FFF0, 32'h8, 32'h0);
        cons_q.delete();
        step();
        s_op = 3'b000;
        run_until(3, 30);
        chk("wrap pc0", cons_q[0], 32'hFFFF_FFF8);
        chk("wrap pc1", cons_q[1], 32'hFFFF_FFFC);
        chk("wrap pc2", cons_q[2], 32'h0);

        // Misaligned target.
        set_redirect(3'b001, 32'h100, 32'h2, 32'h0);
        cons_q.delete();
        step();
        s_op = 3'b000;
`ifdef FETCH_ALIGN_CHK_EN
        repeat (5) step();
        chk("misalign fetch_err", 32'(fetch_err), 32'd1);
        chk("misalign req_valid", 32'(fif.imem_req_valid), 32'd0);
`else
        run_until(1, 20);
        chk("misalign forced pc", cons_q[0], 32'h100);
`endif

        // Reset with traffic in flight, then restart from RESET_PC.
        lat_min = 1; lat_max = 2;
        do_reset();
        s_inst_ready = 1'b0;
        repeat (4) step();
        s_inst_ready = 1'b1;
        do_reset();
        run_until(1, 20);
        chk("restart pc", cons_q[0], RESET_PC);

        // Randomized traffic.
        lat_min = 1; lat_max = 3;
        for (int n = 0; n < 3000; n++) begin
            s_req_ready  = ($urandom_range(3, 0) != 0);
            s_inst_ready = ($urandom_range(9, 0) < 7);
            if ($urandom_range(99, 0) < 6) begin
                s_op    = 3'($urandom);
                s_br_pc = $urandom & ~32'h3;
                s_imm   = ($urandom_range(9, 0) == 0) ? $urandom : ($urandom & ~32'h3);
                s_jb    = $urandom & ~32'h2;
            end else begin
                s_op = 3'b000;
            end
            if ($urandom_range(999, 0) < 3 || (m_halted && $urandom_range(19, 0) == 0)) begin
                do_reset();
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
